// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types, sizes and column decode for the keypad scanner
package key_scan_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} scan_state_t;

  localparam int ROWS        = 4;
  localparam int COLS        = 4;
  localparam int HIST_DIGITS = 6;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_hit_t;

  // Valid only when exactly one column is pulled low; ghosting/multi-press decodes as no key.
  function automatic col_hit_t onehot_low_idx(input logic [COLS-1:0] pat);
    col_hit_t hit;
    int       lows;
    hit  = '0;
    lows = 0;
    for (int i = 0; i < COLS; i++) begin
      if (!pat[i]) begin
        lows    = lows + 1;
        hit.idx = 2'(i);
      end
    end
    hit.valid = (lows == 1);
    return hit;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running divider producing a one-clock tick every TICK_DIV clocks
module scan_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - 4x4 keypad row scanner with press/release debounce and six-digit key history
module key_matrix_scan
  import key_scan_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DB_TICKS = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COLS-1:0]          col_in,
  output logic [ROWS-1:0]          row_out,
  output logic                     key_valid,
  output logic [3:0]               key_code,
  output logic                     key_down,
  output logic [HIST_DIGITS*4-1:0] data_out
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int SW       = $clog2(DB_TICKS + 1);
  localparam int HW       = HIST_DIGITS * 4;
  localparam logic [SW-1:0] DB_MAX = SW'(DB_TICKS);

  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_s;
  logic [COLS-1:0] pat;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [SW-1:0]   stable;
  logic [SW-1:0]   stable_inc;
  logic            tick;
  col_hit_t        hit;
  scan_state_t     state;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign hit        = onehot_low_idx(col_s);
  assign stable_inc = (stable == DB_MAX) ? DB_MAX : stable + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_meta  <= '1;
      col_s     <= '1;
      pat       <= '1;
      row_out   <= 4'b1110;
      row_idx   <= '0;
      col_idx   <= '0;
      stable    <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
      data_out  <= '0;
    end else begin
      col_meta  <= col_in;
      col_s     <= col_meta;
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (hit.valid) begin
              col_idx <= hit.idx;
              pat     <= col_s;
              stable  <= SW'(1);
              state   <= DEBOUNCE;
            end else begin
              row_out <= {row_out[ROWS-2:0], row_out[ROWS-1]};
              row_idx <= row_idx + 1'b1;
            end
          end
          DEBOUNCE: begin
            if (col_s == pat) begin
              stable <= stable_inc;
              // Row is still frozen, so row_idx is the row the key was found on.
              if (stable_inc == DB_MAX) begin
                state     <= PRESSED;
                key_code  <= {row_idx, col_idx};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                data_out  <= {data_out[HW-5:0], row_idx, col_idx};
              end
            end else begin
              stable <= '0;
              state  <= SCAN;
            end
          end
          PRESSED: begin
            if (col_s == '1) begin
              stable <= SW'(1);
              state  <= RELEASE;
            end
          end
          RELEASE: begin
            if (col_s == '1) begin
              stable <= stable_inc;
              if (stable_inc == DB_MAX) begin
                key_down <= 1'b0;
                state    <= SCAN;
                row_out  <= {row_out[ROWS-2:0], row_out[ROWS-1]};
                row_idx  <= row_idx + 1'b1;
              end
            end else begin
              stable <= '0;
              state  <= PRESSED;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - directed bench for key_matrix_scan with a 4x4 keypad model
module tb_key_matrix_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [23:0] data_out;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int doubles = 0;
  logic prev_valid = 1'b0;

  key_matrix_scan #(.CLK_HZ(100), .SCAN_HZ(25), .DB_TICKS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_down (key_down),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Pressed key 4r+c pulls column c low while row r is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) pulses <= pulses + 1;
    if (key_valid && prev_valid) doubles <= doubles + 1;
    prev_valid <= key_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          npulse;
    logic [3:0]  code;
    logic [23:0] data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          p0;
    int          n;
    int          changes;
    logic [3:0]  prev_row;
    logic [3:0]  exp_rows[5];
    logic [23:0] d0;

    vecs[0] = '{16'h0200, 48, 1, 4'h9, 24'h000009};
    vecs[1] = '{16'h0002, 48, 1, 4'h1, 24'h000091};
    vecs[2] = '{16'h0004, 48, 1, 4'h2, 24'h000912};
    vecs[3] = '{16'h0008, 48, 1, 4'h3, 24'h009123};
    vecs[4] = '{16'h0010, 48, 1, 4'h4, 24'h091234};
    vecs[5] = '{16'h0020, 48, 1, 4'h5, 24'h912345};
    vecs[6] = '{16'h0040, 48, 1, 4'h6, 24'h123456};
    vecs[7] = '{16'h8000, 48, 1, 4'hF, 24'h23456F};
    vecs[8] = '{16'h0030, 48, 0, 4'hF, 24'h23456F};
    exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset and free scan
    keys  = '0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_row", 32'(row_out), 32'(exp_rows[0]));
    check("rst_valid", 32'(key_valid), 0);
    check("rst_code", 32'(key_code), 0);
    check("rst_down", 32'(key_down), 0);
    check("rst_data", 32'(data_out), 0);
    repeat (3) @(negedge clk);
    check("row_hold", 32'(row_out), 32'(exp_rows[0]));
    @(negedge clk);
    check("row_seq1", 32'(row_out), 32'(exp_rows[1]));
    for (int i = 2; i < 5; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("row_seq%0d", i), 32'(row_out), 32'(exp_rows[i]));
    end
    check("scan_down", 32'(key_down), 0);
    check("scan_pulses", 32'(pulses), 0);

    // Single-key presses and a ghosted two-column press
    for (int v = 0; v < 9; v++) begin
      p0   = pulses;
      keys = vecs[v].keys;
      repeat (vecs[v].hold) @(negedge clk);
      check($sformatf("v%0d_pulses", v), 32'(pulses - p0), 32'(vecs[v].npulse));
      check($sformatf("v%0d_down", v), 32'(key_down), 32'(vecs[v].npulse));
      check($sformatf("v%0d_code", v), 32'(key_code), 32'(vecs[v].code));
      check($sformatf("v%0d_data", v), 32'(data_out), 32'(vecs[v].data));
      keys = '0;
      n = 0;
      while (key_down && n < 64) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("v%0d_release", v), 32'(key_down), 0);
      repeat (8) @(negedge clk);
    end

    // Bounce: visible for only two ticks
    p0 = pulses;
    d0 = data_out;
    keys = 16'h0001;
    repeat (8) @(negedge clk);
    keys = '0;
    repeat (24) @(negedge clk);
    check("bounce_pulses", 32'(pulses - p0), 0);
    check("bounce_data", 32'(data_out), 32'(d0));
    check("bounce_down", 32'(key_down), 0);
    changes  = 0;
    prev_row = row_out;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (row_out != prev_row) changes++;
      prev_row = row_out;
    end
    check("bounce_rescan", 32'(changes >= 6), 1);

    // Long hold: one pulse, release debounced in three ticks
    p0   = pulses;
    keys = 16'h0001;
    repeat (400) @(negedge clk);
    check("hold_pulses", 32'(pulses - p0), 1);
    check("hold_down", 32'(key_down), 1);
    check("hold_code", 32'(key_code), 0);
    check("hold_data", 32'(data_out), 32'h3456F0);
    keys = '0;
    repeat (10) @(negedge clk);
    check("rel_early", 32'(key_down), 1);
    repeat (4) @(negedge clk);
    check("rel_fall", 32'(key_down), 0);
    check("rel_pulses", 32'(pulses - p0), 1);
    repeat (8) @(negedge clk);

    // Reset in the middle of a debounce
    n = 0;
    prev_row = row_out;
    @(negedge clk);
    while (!(row_out == 4'b1110 && prev_row != 4'b1110) && n < 40) begin
      prev_row = row_out;
      @(negedge clk);
      n++;
    end
    check("align_row0", 32'(row_out), 32'(4'b1110));
    p0   = pulses;
    keys = 16'h0001;
    repeat (9) @(negedge clk);
    check("db_frozen", 32'(row_out), 32'(4'b1110));
    rst_n = 1'b0;
    keys  = '0;
    @(negedge clk);
    check("mid_rst_row", 32'(row_out), 32'(4'b1110));
    check("mid_rst_down", 32'(key_down), 0);
    check("mid_rst_code", 32'(key_code), 0);
    check("mid_rst_data", 32'(data_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_rst_pulses", 32'(pulses - p0), 0);
    check("mid_rst_data2", 32'(data_out), 0);
    check("pulse_width", 32'(doubles), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
